// File: rtl/flp32_accumulator_pkg.sv
// rtl/flp32_accumulator_pkg.sv - shared float constants and FSM state type for the float32 accumulator
package flp32_accumulator_pkg;

  localparam logic [31:0] FLP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FLP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FLP_POS_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } acc_state_t;

endpackage

// File: rtl/flp32_add_sub.sv
// rtl/flp32_add_sub.sv - combinational float32 adder/subtractor, round-to-nearest-even
module flp32_add_sub
  import flp32_accumulator_pkg::*;
(
  input  logic [31:0] X0,
  input  logic [31:0] Y0,
  output logic [31:0] Result_Add,
  output logic [31:0] Result_Sub
);

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic        sr;
    logic [7:0]  ex, ey, exx, eyy, d, field;
    logic [22:0] fx, fy;
    logic [26:0] mx, my, shifted, mask;
    logic [27:0] r;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic        found, sticky, g, rnd;
    logic [30:0] mag;
    if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
      return FLP_QNAN;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
      return (a[31] == b[31]) ? a : FLP_QNAN;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;

    // x is the operand of larger magnitude; the result takes its sign
    if (a[30:0] >= b[30:0]) begin
      ex = a[30:23]; fx = a[22:0]; ey = b[30:23]; fy = b[22:0]; sr = a[31];
    end else begin
      ex = b[30:23]; fx = b[22:0]; ey = a[30:23]; fy = a[22:0]; sr = b[31];
    end
    mx  = {(ex != 8'h0), fx, 3'b000};
    my  = {(ey != 8'h0), fy, 3'b000};
    exx = (ex == 8'h0) ? 8'd1 : ex;
    eyy = (ey == 8'h0) ? 8'd1 : ey;
    d   = exx - eyy;
    if (d > 8'd26) begin
      shifted = 27'h0;
      sticky  = |my;
    end else begin
      mask    = (27'd1 << d) - 27'd1;
      shifted = my >> d;
      sticky  = |(my & mask);
    end
    shifted[0] = shifted[0] | sticky;
    e = {2'b00, exx};

    if (a[31] == b[31]) begin
      r = {1'b0, mx} + {1'b0, shifted};
      if (r[27]) begin
        r = {1'b0, r[27:2], r[1] | r[0]};
        e = e + 10'd1;
      end
    end else begin
      r = {1'b0, mx} - {1'b0, shifted};
      if (r == 28'h0) return FLP_POS_ZERO;
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (r[i]) found = 1'b1;
          else      lz = lz + 5'd1;
        end
      end
      // normalise, but never below the denormal exponent
      if (e > {5'b0, lz}) begin
        r = r << lz;
        e = e - {5'b0, lz};
      end else begin
        r = r << (e - 10'd1);
      end
    end

    if (e >= 10'd255) return {sr, FLP_POS_INF[30:0]};
    field = r[26] ? e[7:0] : 8'h0;
    g     = r[2];
    rnd   = r[1] | r[0];
    // a rounding carry ripples into the exponent, including up to infinity
    mag   = {field, r[25:3]} + {30'h0, g & (rnd | r[3])};
    return {sr, mag};
  endfunction

  assign Result_Add = fadd(X0, Y0);
  assign Result_Sub = fadd(X0, {~Y0[31], Y0[30:0]});

endmodule

// File: rtl/flp32_accumulator.sv
// rtl/flp32_accumulator.sv - streaming float32 accumulator summing len samples per job
module flp32_accumulator
  import flp32_accumulator_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PIPE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  input  logic             i_in_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_data,
  output logic             o_busy
);

  acc_state_t       r_state, w_next;
  logic [31:0]      r_sum, r_out_data, r_op_data;
  logic             r_op_sub;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] w_y0, w_res_add, w_res_sub, w_new_sum;
  logic        w_sub_sel, w_in_ready, w_out_valid, w_accept, w_commit, w_last, w_start_job;

  assign w_y0      = (PIPE != 0) ? r_op_data : i_in_data;
  assign w_sub_sel = (PIPE != 0) ? r_op_sub  : i_in_sub;
  assign w_new_sum = w_sub_sel ? w_res_sub : w_res_add;
  assign w_last    = (r_cnt == CNT_W'(1));

  flp32_add_sub u_add_sub (
    .X0         (r_sum),
    .Y0         (w_y0),
    .Result_Add (w_res_add),
    .Result_Sub (w_res_sub)
  );

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_start_job = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_job = 1'b1;
          w_next      = (i_len == '0) ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept = 1'b1;
          if (PIPE != 0) begin
            w_next = ST_WAIT;
          end else begin
            w_commit = 1'b1;
            w_next   = w_last ? ST_HOLD : ST_ACC;
          end
        end
      end
      ST_WAIT: begin
        w_commit = 1'b1;
        w_next   = w_last ? ST_HOLD : ST_ACC;
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        if (i_out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // abort overrides everything: no accept, no sum write, no new job
    if (i_abort) begin
      w_next      = ST_IDLE;
      w_in_ready  = 1'b0;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      w_start_job = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sum      <= FLP_POS_ZERO;
      r_cnt      <= '0;
      r_out_data <= FLP_POS_ZERO;
      r_op_data  <= FLP_POS_ZERO;
      r_op_sub   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_job) begin
        r_sum <= FLP_POS_ZERO;
        r_cnt <= i_len;
        if (i_len == '0) r_out_data <= FLP_POS_ZERO;
      end
      if (w_accept) begin
        r_op_data <= i_in_data;
        r_op_sub  <= i_in_sub;
      end
      if (w_commit) begin
        r_sum <= w_new_sum;
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) r_out_data <= w_new_sum;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_flp32_accumulator.sv
// tb/tb_flp32_accumulator.sv - directed self-checking bench for flp32_accumulator, PIPE=0 and PIPE=1
module tb_flp32_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_start, s1_start, abort, in_valid, in_sub, out_ready;
  logic [7:0]  len;
  logic [31:0] in_data;

  logic        r0_in_ready, r0_out_valid, r0_busy;
  logic        r1_in_ready, r1_out_valid, r1_busy;
  logic [31:0] r0_out_data, r1_out_data;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  flp32_accumulator #(.CNT_W(8), .PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(s0_start), .i_len(len), .i_abort(abort),
    .i_in_valid(in_valid), .o_in_ready(r0_in_ready), .i_in_data(in_data), .i_in_sub(in_sub),
    .o_out_valid(r0_out_valid), .i_out_ready(out_ready), .o_out_data(r0_out_data), .o_busy(r0_busy)
  );

  flp32_accumulator #(.CNT_W(8), .PIPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(s1_start), .i_len(len), .i_abort(abort),
    .i_in_valid(in_valid), .o_in_ready(r1_in_ready), .i_in_data(in_data), .i_in_sub(in_sub),
    .o_out_valid(r1_out_valid), .i_out_ready(out_ready), .o_out_data(r1_out_data), .o_busy(r1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s0_start = 1'b0; s1_start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_sub = 1'b0; out_ready = 1'b0; len = 8'd0; in_data = 32'h0;
    #1;
    chk("rst0_in_ready",  {31'h0, r0_in_ready},  32'h0);
    chk("rst0_out_valid", {31'h0, r0_out_valid}, 32'h0);
    chk("rst0_out_data",  r0_out_data,           32'h0);
    chk("rst0_busy",      {31'h0, r0_busy},      32'h0);
    chk("rst1_busy",      {31'h0, r1_busy},      32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: 579 + 456 = 1035
    s0_start = 1'b1; len = 8'd2;
    tick();
    s0_start = 1'b0;
    chk("t1_busy", {31'h0, r0_busy}, 32'h1);
    chk("t1_in_ready", {31'h0, r0_in_ready}, 32'h1);
    in_valid = 1'b1; in_data = 32'h4410_C000; in_sub = 1'b0;
    tick();
    chk("t1_no_valid_early", {31'h0, r0_out_valid}, 32'h0);
    in_data = 32'h43E4_0000;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", {31'h0, r0_out_valid}, 32'h1);
    chk("t1_out_data", r0_out_data, 32'h4481_6000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_idle_valid", {31'h0, r0_out_valid}, 32'h0);
    chk("t1_idle_busy", {31'h0, r0_busy}, 32'h0);

    // 2: 579 - 456 = 123
    s0_start = 1'b1; len = 8'd2;
    tick();
    s0_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h4410_C000; in_sub = 1'b0;
    tick();
    in_data = 32'h43E4_0000; in_sub = 1'b1;
    tick();
    in_valid = 1'b0; in_sub = 1'b0;
    chk("t2_out_valid", {31'h0, r0_out_valid}, 32'h1);
    chk("t2_out_data", r0_out_data, 32'h42F6_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 3: len=0 goes straight to HOLD with +0; start in HOLD ignored
    s0_start = 1'b1; len = 8'd0;
    tick();
    s0_start = 1'b0;
    chk("t3_out_valid", {31'h0, r0_out_valid}, 32'h1);
    chk("t3_out_data", r0_out_data, 32'h0);
    s0_start = 1'b1; len = 8'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", {31'h0, r0_out_valid}, 32'h1);
      chk("t3_hold_data", r0_out_data, 32'h0);
      chk("t3_hold_no_ready", {31'h0, r0_in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_after_hs_busy", {31'h0, r0_busy}, 32'h0);
    chk("t3_after_hs_valid", {31'h0, r0_out_valid}, 32'h0);
    s0_start = 1'b0;
    tick();
    chk("t3_start_in_hs_ignored", {31'h0, r0_busy}, 32'h0);

    // 4: PIPE=1, 1.0 x 3 with in_valid held high
    s1_start = 1'b1; len = 8'd3;
    tick();
    s1_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h3F80_0000;
    #1;
    chk("t4_ready_0", {31'h0, r1_in_ready}, 32'h1);
    tick(); chk("t4_ready_1", {31'h0, r1_in_ready}, 32'h0);
    tick(); chk("t4_ready_2", {31'h0, r1_in_ready}, 32'h1);
    tick(); chk("t4_ready_3", {31'h0, r1_in_ready}, 32'h0);
    tick(); chk("t4_ready_4", {31'h0, r1_in_ready}, 32'h1);
    tick();
    chk("t4_wait_valid", {31'h0, r1_out_valid}, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("t4_out_valid", {31'h0, r1_out_valid}, 32'h1);
    chk("t4_out_data", r1_out_data, 32'h4040_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_idle_busy", {31'h0, r1_busy}, 32'h0);

    // 5: abort after one of three samples, then a fresh len=1 job of 2.0
    s0_start = 1'b1; len = 8'd3;
    tick();
    s0_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h3F80_0000;
    tick();
    abort = 1'b1;
    #1;
    chk("t5_abort_ready", {31'h0, r0_in_ready}, 32'h0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("t5_abort_busy", {31'h0, r0_busy}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_never_valid", {31'h0, r0_out_valid}, 32'h0);
    end
    s0_start = 1'b1; len = 8'd1;
    tick();
    s0_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h4000_0000;
    tick();
    in_valid = 1'b0;
    chk("t5_new_valid", {31'h0, r0_out_valid}, 32'h1);
    chk("t5_new_data", r0_out_data, 32'h4000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 6: asynchronous reset between edges mid-ACC
    s0_start = 1'b1; len = 8'd2;
    tick();
    s0_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h3F80_0000;
    tick();
    chk("t6_mid_busy", {31'h0, r0_busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", {31'h0, r0_in_ready}, 32'h0);
    chk("t6_rst_busy", {31'h0, r0_busy}, 32'h0);
    chk("t6_rst_out_valid", {31'h0, r0_out_valid}, 32'h0);
    chk("t6_rst_out_data", r0_out_data, 32'h0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_busy", {31'h0, r0_busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
